// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared register-file widths and writeback request types.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register busy bits for outstanding loads, two lookup ports.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  reg_addr_t   set_rd,
    input  logic        clr_en,
    input  reg_addr_t   clr_rd,
    input  reg_addr_t   rd_a,
    output logic        busy_a,
    input  reg_addr_t   rd_b,
    output logic        busy_b,
    output logic [31:0] busy_vec
);

    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;

    // Clear is applied first so a same-cycle set of the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (clr_en && (clr_rd != '0)) begin
            w_busy_nxt[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != '0)) begin
            w_busy_nxt[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_a   = r_busy[rd_a];
    assign busy_b   = r_busy[rd_b];
    assign busy_vec = r_busy;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Arbitrates ALU/LSU writeback onto the single regfile write port
//               with load-starvation protection and decode hazard flags.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  reg_addr_t       alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  reg_addr_t       lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  reg_addr_t       iss_rd,
    input  reg_addr_t       chk_rs1,
    input  reg_addr_t       chk_rs2,
    output logic            hazard1,
    output logic            hazard2,
    output logic            rf_wen,
    output reg_addr_t       rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            pending
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    logic [3:0]  r_wait_cnt;
    logic        w_forced;
    logic        w_busy1;
    logic        w_busy2;
    logic [31:0] w_busy_vec;

    assign w_forced  = (r_wait_cnt == c_max_wait);
    assign alu_ready = w_forced ? (alu_valid & ~lsu_valid) : alu_valid;
    assign lsu_ready = w_forced ? lsu_valid : (lsu_valid & ~alu_valid);
    assign iss_ready = (iss_rd == '0) | ~w_busy_vec[iss_rd];

    rf_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_valid & iss_ready),
        .set_rd   (iss_rd),
        .clr_en   (lsu_ready),
        .clr_rd   (lsu_rd),
        .rd_a     (chk_rs1),
        .busy_a   (w_busy1),
        .rd_b     (chk_rs2),
        .busy_b   (w_busy2),
        .busy_vec (w_busy_vec)
    );

    // The rf_wen term covers the cycle where the load data is on its way into the regfile.
    assign hazard1 = (chk_rs1 != '0) & (w_busy1 | (rf_wen & (rf_waddr == chk_rs1)));
    assign hazard2 = (chk_rs2 != '0) & (w_busy2 | (rf_wen & (rf_waddr == chk_rs2)));
    assign pending = |w_busy_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!lsu_valid || lsu_ready) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_max_wait) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Grants to x0 are consumed without asserting the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (alu_ready) begin
            rf_wen   <= (alu_rd != '0);
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
        end else if (lsu_ready) begin
            rf_wen   <= (lsu_rd != '0);
            rf_waddr <= lsu_rd;
            rf_wdata <= lsu_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

endmodule : rf_wb_arbiter
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Self-checking bench for rf_wb_arbiter with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;
    import rv32i_pkg::*;

    localparam int c_max_wait = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    reg_addr_t   alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    reg_addr_t   lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_valid, iss_ready;
    reg_addr_t   iss_rd, chk_rs1, chk_rs2;
    logic        hazard1, hazard2, rf_wen, pending;
    reg_addr_t   rf_waddr;
    logic [31:0] rf_wdata;

    rf_wb_arbiter #(.MAX_WAIT(c_max_wait), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard1(hazard1), .hazard2(hazard2),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    wb_req_t     exp_q[$];
    logic [31:0] m_busy = '0;
    int          m_wait = 0;
    logic        m_wen  = 1'b0;
    reg_addr_t   m_waddr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs, then advance the model.
    task automatic cyc(input logic r, input logic av, input reg_addr_t ard, input logic [31:0] ad,
                       input logic lv, input reg_addr_t lrd, input logic [31:0] ld,
                       input logic iv, input reg_addr_t ird, input reg_addr_t s1, input reg_addr_t s2);
        wb_req_t e;
        logic    forced, m_ar, m_lr, m_ir, h1, h2;
        @(negedge clk);
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        iss_valid = iv; iss_rd = ird; chk_rs1 = s1; chk_rs2 = s2;
        #1;
        check("rf_wen", 32'(rf_wen), 32'(m_wen));
        if (m_wen) begin
            e = exp_q.pop_front();
            m_waddr = e.rd;
            check("rf_waddr", 32'(rf_waddr), 32'(e.rd));
            check("rf_wdata", rf_wdata, e.data);
        end
        check("pending", 32'(pending), 32'(|m_busy));
        forced = (m_wait == c_max_wait);
        m_ar = forced ? (av & ~lv) : av;
        m_lr = forced ? lv : (lv & ~av);
        m_ir = (ird == 0) || !m_busy[ird];
        h1 = (s1 != 0) && (m_busy[s1] || (m_wen && m_waddr == s1));
        h2 = (s2 != 0) && (m_busy[s2] || (m_wen && m_waddr == s2));
        check("alu_ready", 32'(alu_ready), 32'(m_ar));
        check("lsu_ready", 32'(lsu_ready), 32'(m_lr));
        check("iss_ready", 32'(iss_ready), 32'(m_ir));
        check("hazard1", 32'(hazard1), 32'(h1));
        check("hazard2", 32'(hazard2), 32'(h2));
        if (m_ar && ard != 0 && m_busy[ard])
            $error("upstream error: ALU writeback to busy register x%0d", ard);
        if (r) begin
            m_busy = '0; m_wait = 0; m_wen = 1'b0;
        end else begin
            m_wen = 1'b0;
            if (m_ar && ard != 0) begin
                exp_q.push_back('{rd: ard, data: ad}); m_wen = 1'b1;
            end else if (!m_ar && m_lr && lrd != 0) begin
                exp_q.push_back('{rd: lrd, data: ld}); m_wen = 1'b1;
            end
            if (m_lr && lrd != 0) m_busy[lrd] = 1'b0;
            if (iv && m_ir && ird != 0) m_busy[ird] = 1'b1;
            if (!lv || m_lr) m_wait = 0;
            else if (m_wait < c_max_wait) m_wait++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0; lsu_valid = 0; lsu_rd = 0;
        lsu_data = 0; iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
        // Reset and idle
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        check("rst_waddr", 32'(rf_waddr), 32'h0);
        check("rst_wdata", rf_wdata, 32'h0);
        // Single ALU write
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("alu_wdata", rf_wdata, 32'hDEADBEEF);
        // Simultaneous ALU/LSU: ALU first, LSU next
        cyc(0, 1, 3, 32'h0000_0333, 1, 4, 32'h0000_0444, 0, 0, 0, 0);
        cyc(0, 0, 0, 0,             1, 4, 32'h0000_0444, 0, 0, 0, 0);
        idle(2);
        // LSU starvation: forced grant on the fifth refused cycle
        for (int i = 0; i < 6; i++)
            cyc(0, 1, reg_addr_t'(16 + i), 32'hA000_0000 + i, (i < 5), 11, 32'hB000_0011, 0, 0, 0, 0);
        idle(2);
        // Load issue scoreboard and hazard window
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
        cyc(0, 0, 0, 0, 1, 7, 32'h7777_7777, 0, 0, 7, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        // Same-cycle set and clear of x9: set wins
        cyc(0, 0, 0, 0, 1, 9, 32'h9999_9999, 1, 9, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        check("busy9_kept", 32'(pending), 32'h1);
        cyc(0, 0, 0, 0, 1, 9, 32'h9999_0000, 0, 0, 9, 0);
        idle(2);
        // ALU write to x0 is consumed silently
        cyc(0, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Reset during a grant with an outstanding load
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
        cyc(1, 1, 6, 32'h6666_6666, 0, 0, 0, 0, 0, 12, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 6);
        check("rst_pending", 32'(pending), 32'h0);
        idle(1);
        // Random traffic; ALU never targets a busy register
        for (int i = 0; i < 300; i++) begin
            logic      av, lv, iv;
            reg_addr_t ard, lrd, ird;
            av  = ($urandom_range(0, 99) < 55);
            lv  = ($urandom_range(0, 99) < 45);
            iv  = ($urandom_range(0, 99) < 30);
            ard = reg_addr_t'($urandom_range(0, 31));
            lrd = reg_addr_t'($urandom_range(0, 31));
            ird = reg_addr_t'($urandom_range(0, 31));
            if (m_busy[ard]) av = 1'b0;
            cyc(0, av, ard, $urandom, lv, lrd, $urandom, iv, ird,
                reg_addr_t'($urandom_range(0, 31)), reg_addr_t'($urandom_range(0, 31)));
        end
        idle(2);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rf_wb_arbiter
`default_nettype wire
